bigadd_sched: RTL and testbench
===============================

# bigadd_sched

Round-robin scheduler that shares one `adder_400bit` instance between `NREQ` requesters. A granted requester streams its operands byte-serially into operand registers. The scheduler pulses the adder's `start`, waits for `done` under a timeout, then streams the sum back byte-serially. It sits between client logic and the adder and owns the adder's `start`, `a` and `b` inputs.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `NBYTES`, 50: operand width in bytes; byte i occupies bits [8i+7:8i] of every flat vector.
- `TIMEOUT`, 1024: maximum cycles in WAIT before the operation is aborted.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: request line per client; sampled only in IDLE.
- `gnt` out NREQ: one-hot grant, held from LOAD through end of DRAIN.
- `in_valid` in 1: operand byte pair valid, from the granted client.
- `in_ready` out 1: high in LOAD only.
- `in_a`, `in_b` in 8: operand bytes, index 0 first.
- `out_valid` out 1: result byte valid.
- `out_ready` in 1: client accepts result byte.
- `out_data` out 8: sum byte, index 0 first.
- `out_last` out 1: marks byte NBYTES-1.
- `out_id` out $clog2(NREQ): owner of the current result.
- `err` out 1: one-cycle pulse on timeout.
- `err_id` out $clog2(NREQ): requester that timed out; valid with `err`.
- `add_start` out 1: one-cycle start pulse to the adder.
- `add_done` in 1: adder completion.
- `add_a`, `add_b` out 8·NBYTES: operand registers.
- `add_sum` in 8·NBYTES: adder result.

## Operation
- **States:**
  - IDLE→LOAD when any `req` bit is set.
  - LOAD→START after byte NBYTES-1 is accepted.
  - START→WAIT unconditionally.
  - WAIT→DRAIN on `add_done`.
  - WAIT→IDLE on timeout.
  - DRAIN→IDLE on the `out_last` handshake.
- **Arbitration:** round-robin in IDLE. Search starts at the index after the last granted requester; after reset the last-granted pointer is NREQ-1, so requester 0 has priority. The pointer updates only when a grant is issued.
- **LOAD:** a byte pair is written to index `cnt` on `in_valid & in_ready`, then `cnt` increments. With `in_valid` low the scheduler stalls indefinitely; there is no timeout in LOAD.
- **START:** `add_start`=1 for exactly this cycle. The WAIT counter is cleared.
- **WAIT:**
  - Counter increments every cycle.
  - If `add_done` is seen, `add_sum` is latched into the result register that same cycle.
  - If the counter reaches TIMEOUT-1 without `add_done`, `err`=1 and `err_id`=owner for one cycle, and the state goes to IDLE with no result output.
  - If `add_done` and the timeout coincide, `add_done` wins.
- **DRAIN:** `out_data` = result byte `cnt`. On `out_valid & out_ready` the index advances. `out_valid` stays high and data stays stable until accepted.
- **Requests during an operation:** deasserting `req` mid-operation has no effect; the transaction completes. New requests wait for IDLE.
- `add_done` outside WAIT is ignored.
- **Reset values:**
  - State IDLE.
  - `gnt`=0, `in_ready`=0, `out_valid`=0, `out_last`=0, `add_start`=0, `err`=0.
  - `out_data`, `out_id`, `err_id` = 0.
  - Operand and result registers = 0.
  - Arbiter pointer = NREQ-1.
- **Reset mid-operation:** `rst` aborts immediately to the reset values. No output pulses are generated.

## Timing
- Cycle 0: `req` seen in IDLE. Cycle 1: `gnt` and `in_ready` registered high.
- LOAD takes a minimum of NBYTES cycles.
- `add_start` is asserted the cycle after the last byte is accepted.
- First `out_valid` is asserted the cycle after `add_done` is sampled.
- DRAIN takes a minimum of NBYTES cycles at full throughput.
- `gnt` drops the cycle after the last handshake. The next grant is possible one cycle later, from IDLE.
- Minimum turnaround with adder latency L: 1 + NBYTES + 1 + L + 1 + NBYTES cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `bigadd_pkg`: state encoding (IDLE, LOAD, START, WAIT, DRAIN) and default constants NBYTES=50 and TIMEOUT=1024.
- Sub-module `rr_arbiter` (parameter NREQ): inputs `req` and `en`; outputs one-hot `gnt` and a binary index. It owns the pointer.
- One `cnt` of $clog2(NBYTES) bits is shared by LOAD and DRAIN. The WAIT counter is separate, $clog2(TIMEOUT) bits.

## Test plan
- Single request: `req`=01, a bytes all 0xFF, b = 0x01 at index 0 and zero elsewhere. Use an adder model with L=10. Expect `add_start` one pulse, output bytes all 0x00, `out_last` on byte 49, `out_id`=0.
- Contention: `req`=11 held continuously for 3 transactions. Expect grant order 0,1,0 and `out_id` to match each transaction.
- Backpressure: toggle `out_ready` every cycle and drop `in_valid` for 5 cycles mid-LOAD. Expect every byte delivered exactly once, in order, and `out_data` stable while stalled.
- Timeout: adder model never asserts done, TIMEOUT=16. Expect `err` one cycle exactly 16 cycles after `add_start` with the correct `err_id`, return to IDLE, and no `out_valid`.
- Reset mid-DRAIN: assert `rst` after byte 20. Expect all outputs at reset values immediately. After release, `req`=10 is granted to requester 0's rival per pointer reset, so requester 1 gets the next transaction.
- Coincident done and timeout: `add_done` exactly at cycle TIMEOUT-1. Expect a normal DRAIN and no `err`.

Source files
------------

// File: rtl/bigadd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bigadd_pkg
// Description : Shared state encoding and default sizing for bigadd_sched.
// Revision    : 1.0 - initial release
// ============================================================================
package bigadd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int c_def_nbytes  = 50;
    localparam int c_def_timeout = 1024;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin request picker; pointer advances only on grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    int              w_pos;

    // Search begins one past the last granted requester and wraps around.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_pos = (int'(r_ptr) + i) % NREQ;
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                w_gnt[w_pos] = 1'b1;
                w_idx        = IW'(w_pos);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IW'(NREQ - 1);
        end else if (en && w_found) begin
            r_ptr <= w_idx;
        end
    end

    assign gnt = w_gnt;
    assign idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/bigadd_sched.sv
`default_nettype none
// ============================================================================
// Module      : bigadd_sched
// Description : Shares one wide adder among NREQ clients with byte-serial I/O.
// Revision    : 1.0 - initial release
// ============================================================================
module bigadd_sched
    import bigadd_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NBYTES  = c_def_nbytes,
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_a,
    input  logic [7:0]              in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    err,
    output logic [$clog2(NREQ)-1:0] err_id,
    output logic                    add_start,
    input  logic                    add_done,
    output logic [8*NBYTES-1:0]     add_a,
    output logic [8*NBYTES-1:0]     add_b,
    input  logic [8*NBYTES-1:0]     add_sum
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(NBYTES);
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] c_cnt_last  = CW'(NBYTES - 1);
    // Decided one cycle early so the registered err lands TIMEOUT cycles after start.
    localparam logic [WW-1:0] c_wait_last = WW'(TIMEOUT - 2);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [WW-1:0]       r_wcnt;
    logic [NREQ-1:0]     r_gnt;
    logic [IW-1:0]       r_owner;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic                r_out_last;
    logic                r_err;
    logic [IW-1:0]       r_err_id;
    logic                r_add_start;
    logic [8*NBYTES-1:0] r_add_a;
    logic [8*NBYTES-1:0] r_add_b;
    logic [8*NBYTES-1:0] r_result;

    logic [NREQ-1:0]     w_arb_gnt;
    logic [IW-1:0]       w_arb_idx;
    logic                w_arb_en;
    logic [CW-1:0]       w_cnt_nxt;

    assign w_arb_en  = (r_state == ST_IDLE) && (|req);
    assign w_cnt_nxt = r_cnt + CW'(1);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (w_arb_en),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wcnt      <= '0;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_err_id    <= '0;
            r_add_start <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_result    <= '0;
        end else begin
            r_add_start <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_en) begin
                        r_gnt      <= w_arb_gnt;
                        r_owner    <= w_arb_idx;
                        r_in_ready <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_add_a[{r_cnt, 3'b000} +: 8] <= in_a;
                        r_add_b[{r_cnt, 3'b000} +: 8] <= in_b;
                        if (r_cnt == c_cnt_last) begin
                            r_in_ready  <= 1'b0;
                            r_add_start <= 1'b1;
                            r_state     <= ST_START;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                ST_START: begin
                    r_wcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes precedence over an expiring timeout.
                    if (add_done) begin
                        r_result    <= add_sum;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= add_sum[7:0];
                        r_out_last  <= (c_cnt_last == '0);
                        r_state     <= ST_DRAIN;
                    end else if (r_wcnt == c_wait_last) begin
                        r_err    <= 1'b1;
                        r_err_id <= r_owner;
                        r_gnt    <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + WW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_gnt       <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_out_data <= r_result[{w_cnt_nxt, 3'b000} +: 8];
                            r_out_last <= (w_cnt_nxt == c_cnt_last);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_id    = r_owner;
    assign err       = r_err;
    assign err_id    = r_err_id;
    assign add_start = r_add_start;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;

endmodule
`default_nettype wire

// File: tb/tb_bigadd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bigadd_sched
// Description : Directed self-checking bench for bigadd_sched with adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bigadd_sched;

    localparam int NR = 2;
    localparam int NB = 50;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req;
    logic [NR-1:0]   gnt;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_a;
    logic [7:0]      in_b;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_last;
    logic [0:0]      out_id;
    logic            err;
    logic [0:0]      err_id;
    logic            add_start;
    logic            add_done = 1'b0;
    logic [8*NB-1:0] add_a;
    logic [8*NB-1:0] add_b;
    logic [8*NB-1:0] add_sum;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 10;
    bit hang = 1'b0;

    logic [7:0] opa [NB];
    logic [7:0] opb [NB];
    logic [7:0] expd[NB];

    logic [7:0] rx_data[$];
    bit         rx_last[$];
    int         rx_id[$];
    int  n_start = 0, n_err = 0, n_ov = 0;
    int  start_cyc = 0, err_cyc = 0, fv_cyc = 0;
    int  err_id_seen = 0;
    bit  stall_pend = 1'b0, prev_valid = 1'b0;
    logic [7:0] held = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Sum is only meaningful during the done cycle, so late latching shows up.
    assign add_sum = add_done ? (add_a + add_b) : {(8*NB){1'b1}};

    bigadd_sched #(
        .NREQ    (NR),
        .NBYTES  (NB),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .err       (err),
        .err_id    (err_id),
        .add_start (add_start),
        .add_done  (add_done),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Adder model: done pulses for one cycle, lat cycles after start.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (add_start && !hang) begin
                repeat (lat) @(posedge clk);
                #1 add_done = 1'b1;
                @(posedge clk);
                #1 add_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_data", out_data, held);
                check("hold_valid", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                rx_id.push_back(int'(out_id));
            end
            stall_pend = out_valid && !out_ready;
            held       = out_data;
            if (out_valid && !prev_valid) fv_cyc = cyc;
            prev_valid = out_valid;
            if (out_valid) n_ov++;
            if (add_start) begin n_start++; start_cyc = cyc; end
            if (err) begin n_err++; err_cyc = cyc; err_id_seen = int'(err_id); end
        end
    end

    task automatic set_ops(input bit ones, input int k);
        for (int i = 0; i < NB; i++) begin
            if (ones) begin
                opa[i]  = 8'hFF;
                opb[i]  = (i == 0) ? 8'h01 : 8'h00;
                expd[i] = 8'h00;
            end else begin
                opa[i]  = 8'(i);
                opb[i]  = 8'(2 * i + k);
                expd[i] = 8'(3 * i + k);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_add_start"}, add_start, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_id"}, out_id, 0);
        check({tag, "_err_id"}, err_id, 0);
        check({tag, "_add_a_nz"}, (add_a != '0), 0);
        check({tag, "_add_b_nz"}, (add_b != '0), 0);
    endtask

    task automatic wait_grant(input logic [NR-1:0] exp_gnt, input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!in_ready && n < 20);
        check({tag, "_grant_lat"}, n, 1);
        check({tag, "_gnt"}, gnt, exp_gnt);
    endtask

    task automatic load_ops(input int gap_at);
        int i = 0;
        int g = 5;
        int n = 0;
        while (i < NB && n < 400) begin
            if (i == gap_at && g > 0) begin
                in_valid = 1'b0;
                g--;
            end else begin
                in_valid = 1'b1;
                in_a     = opa[i];
                in_b     = opb[i];
            end
            @(posedge clk); #1;
            n++;
            if (in_valid) i++;
        end
        in_valid = 1'b0;
        check("load_bytes", i, NB);
    endtask

    task automatic drain(input int nbytes, input bit toggle);
        int target = rx_data.size() + nbytes;
        int n = 0;
        out_ready = 1'b1;
        while (rx_data.size() < target && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (toggle) out_ready = ~out_ready;
        end
        out_ready = 1'b0;
        check("drain_done", (rx_data.size() >= target), 1'b1);
    endtask

    task automatic check_result(input int base, input int exp_id, input string tag);
        int bad_d = 0, bad_l = 0, bad_i = 0;
        for (int i = 0; i < NB; i++) begin
            if (base + i < rx_data.size()) begin
                if (rx_data[base+i] !== expd[i]) bad_d++;
                if (rx_last[base+i] !== (i == NB - 1)) bad_l++;
                if (rx_id[base+i] != exp_id) bad_i++;
            end
        end
        check({tag, "_count"}, rx_data.size() - base, NB);
        check({tag, "_bad_data"}, bad_d, 0);
        check({tag, "_bad_last"}, bad_l, 0);
        check({tag, "_bad_id"}, bad_i, 0);
    endtask

    task automatic txn(input logic [NR-1:0] exp_gnt, input int exp_id, input int gap_at,
                       input bit toggle, input bit drop, input string tag);
        int sn, se, base;
        wait_grant(exp_gnt, tag);
        if (drop) req = '0;
        sn   = n_start;
        se   = n_err;
        base = rx_data.size();
        load_ops(gap_at);
        drain(NB, toggle);
        check({tag, "_gnt_drop"}, gnt, 0);
        check({tag, "_start_pulses"}, n_start - sn, 1);
        check({tag, "_done_to_valid"}, fv_cyc - start_cyc, lat + 1);
        check({tag, "_no_err"}, n_err - se, 0);
        check_result(base, exp_id, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sn, se, sov, n, base;
        req = '0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Contention with req held: 0, 1, 0
        req = 2'b11;
        set_ops(1'b0, 0); txn(2'b01, 0, -1, 1'b0, 1'b0, "cont0");
        set_ops(1'b0, 1); txn(2'b10, 1, -1, 1'b0, 1'b0, "cont1");
        set_ops(1'b0, 2); txn(2'b01, 0, -1, 1'b0, 1'b1, "cont2");

        // All-ones plus one wraps to zero
        req = 2'b01;
        set_ops(1'b1, 0); txn(2'b01, 0, -1, 1'b0, 1'b1, "single");
        check("single_add_a_top", add_a[8*NB-1 -: 8], 8'hFF);
        check("single_add_b_low", add_b[7:0], 8'h01);

        // Load gap plus toggling out_ready
        req = 2'b01;
        set_ops(1'b0, 5); txn(2'b01, 0, 20, 1'b1, 1'b1, "bp");

        // Adder hangs
        hang = 1'b1;
        req  = 2'b10;
        set_ops(1'b0, 3);
        wait_grant(2'b10, "to");
        req = '0;
        sn = n_start; se = n_err; sov = n_ov;
        load_ops(-1);
        n = 0;
        while (n_err == se && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("to_start_pulses", n_start - sn, 1);
        check("to_err_cycles", n_err - se, 1);
        check("to_err_delay", err_cyc - start_cyc, TO);
        check("to_err_id", err_id_seen, 1);
        check("to_no_out_valid", n_ov - sov, 0);
        check("to_gnt_idle", gnt, 0);
        check("to_in_ready_idle", in_ready, 0);
        hang = 1'b0;

        // Done arrives in the last possible WAIT cycle
        lat = TO - 1;
        req = 2'b01;
        set_ops(1'b0, 4); txn(2'b01, 0, -1, 1'b0, 1'b1, "coin");
        lat = 10;

        // Reset after byte 20 of the result
        req = 2'b10;
        set_ops(1'b0, 1);
        wait_grant(2'b10, "rd");
        req  = '0;
        base = rx_data.size();
        load_ops(-1);
        drain(21, 1'b0);
        check("rd_bytes_before_rst", rx_data.size() - base, 21);
        check("rd_out_id_before", out_id, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("rd");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        req = 2'b10;
        set_ops(1'b0, 6); txn(2'b10, 1, -1, 1'b0, 1'b1, "post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
